// File: rtl/tx_bb_sample_buf_if.sv
// tx_bb_sample_buf_if: sample write handshake from the transmit core and pop/data path to dac_intf.
interface tx_bb_sample_buf_if #(
  parameter int IQ_DATA_WIDTH = 16
);
  logic [2*IQ_DATA_WIDTH-1:0] iq_in;
  logic                       iq_in_valid;
  logic                       iq_in_last;
  logic                       iq_in_fulln;
  logic                       read_bb_fifo;
  logic [2*IQ_DATA_WIDTH-1:0] data_to_dac;
  modport master (
    output iq_in, iq_in_valid, iq_in_last, read_bb_fifo,
    input  iq_in_fulln, data_to_dac
  );
  modport slave (
    input  iq_in, iq_in_valid, iq_in_last, read_bb_fifo,
    output iq_in_fulln, data_to_dac
  );
endinterface

// File: rtl/tx_bb_sample_buf.sv
// tx_bb_sample_buf: prefilling IQ sample FIFO feeding dac_intf, with underrun/overflow tracking.
module tx_bb_sample_buf #(
  parameter int IQ_DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH_LOG2 = 6
) (
  input  logic                       acc_clk,
  input  logic                       acc_rstn,
  tx_bb_sample_buf_if.slave          bb,
  input  logic [FIFO_DEPTH_LOG2-1:0] prefill_thresh,
  input  logic                       cnt_clear,
  output logic                       tx_active,
  output logic                       tx_done,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic [15:0]                underrun_count,
  output logic                       overflow
);
  localparam int SW = 2*IQ_DATA_WIDTH;
  localparam int LW = FIFO_DEPTH_LOG2 + 1;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL = LW'(1 << FIFO_DEPTH_LOG2);
  localparam logic [1:0] IDLE = 2'd0, PREFILL = 2'd1, STREAM = 2'd2;
  logic [SW:0] mem [1 << FIFO_DEPTH_LOG2];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0] last_cnt, thresh;
  logic [1:0] state;
  logic [SW:0] head;
  logic streaming, wr_en, pop, pop_last, underrun;
  always_comb begin
    streaming = state == STREAM;
    head = mem[rd_ptr];
    bb.iq_in_fulln = fifo_level != FULL;
    wr_en = bb.iq_in_valid && bb.iq_in_fulln;
    pop = streaming && bb.read_bb_fifo && fifo_level != '0;
    pop_last = pop && head[SW];
    underrun = streaming && bb.read_bb_fifo && fifo_level == '0 && underrun_count != 16'hFFFF;
    thresh = prefill_thresh == '0 ? LW'(1) : {1'b0, prefill_thresh};
    bb.data_to_dac = (streaming && fifo_level != '0) ? head[SW-1:0] : '0;
    tx_active = streaming;
  end
  always_ff @(posedge acc_clk) begin
    if (wr_en) mem[wr_ptr] <= {bb.iq_in_last, bb.iq_in};
  end
  always_ff @(posedge acc_clk) begin
    if (!acc_rstn) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      last_cnt       <= '0;
      tx_done        <= 1'b0;
      underrun_count <= '0;
      overflow       <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(wr_en) - LW'(pop);
      last_cnt <= last_cnt + LW'(wr_en && bb.iq_in_last) - LW'(pop_last);
      tx_done <= pop_last;
      underrun_count <= cnt_clear ? '0 : underrun_count + 16'(underrun);
      overflow <= !cnt_clear && (overflow || (bb.iq_in_valid && !bb.iq_in_fulln));
      // a non-empty buffer in IDLE holds the next packet, so prefill restarts without a new write
      state <= state == IDLE    ? ((wr_en || fifo_level != '0) ? PREFILL : IDLE) :
               state == PREFILL ? ((fifo_level >= thresh || last_cnt != '0) ? STREAM : PREFILL) :
                                  (pop_last ? IDLE : STREAM);
    end
  end
endmodule

// File: tb/tb_tx_bb_sample_buf.sv
// tb_tx_bb_sample_buf: directed checks of prefill, streaming, underrun, overflow, wrap and reset.
module tb_tx_bb_sample_buf;
  logic        acc_clk;
  logic        acc_rstn;
  logic [5:0]  prefill_thresh;
  logic        cnt_clear;
  logic        tx_active;
  logic        tx_done;
  logic [6:0]  fifo_level;
  logic [15:0] underrun_count;
  logic        overflow;
  int total = 0;
  int bad = 0;
  tx_bb_sample_buf_if #(.IQ_DATA_WIDTH(16)) bus ();
  tx_bb_sample_buf #(.IQ_DATA_WIDTH(16), .FIFO_DEPTH_LOG2(6)) dut (
    .acc_clk        (acc_clk),
    .acc_rstn       (acc_rstn),
    .bb             (bus.slave),
    .prefill_thresh (prefill_thresh),
    .cnt_clear      (cnt_clear),
    .tx_active      (tx_active),
    .tx_done        (tx_done),
    .fifo_level     (fifo_level),
    .underrun_count (underrun_count),
    .overflow       (overflow)
  );
  initial acc_clk = 1'b0;
  always #5 acc_clk = ~acc_clk;
  task automatic tick();
    @(posedge acc_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] s, input logic l);
    bus.iq_in = s;
    bus.iq_in_last = l;
    bus.iq_in_valid = 1'b1;
    tick();
    bus.iq_in_valid = 1'b0;
    bus.iq_in_last = 1'b0;
  endtask
  task automatic pop();
    bus.read_bb_fifo = 1'b1;
    tick();
    bus.read_bb_fifo = 1'b0;
  endtask
  task automatic do_reset();
    acc_rstn = 1'b0;
    tick();
    tick();
    acc_rstn = 1'b1;
  endtask
  initial begin
    int wn, rn, dones, cyc, pause_cnt;
    logic acc, popd;
    acc_rstn = 1'b0;
    prefill_thresh = 6'd8;
    cnt_clear = 1'b0;
    bus.iq_in = '0;
    bus.iq_in_valid = 1'b0;
    bus.iq_in_last = 1'b0;
    bus.read_bb_fifo = 1'b0;
    do_reset();
    chk("rst_fulln", bus.iq_in_fulln, 1);
    chk("rst_data", bus.data_to_dac, 0);
    chk("rst_active", tx_active, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_underrun", underrun_count, 0);
    chk("rst_overflow", overflow, 0);
    for (int i = 1; i <= 8; i++) wr(i, 1'b0);
    chk("thr_level8", fifo_level, 8);
    chk("thr_not_yet", tx_active, 0);
    tick();
    chk("thr_active", tx_active, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("thr_order", bus.data_to_dac, i);
      pop();
      tick();
    end
    chk("thr_empty_data", bus.data_to_dac, 0);
    chk("thr_still_stream", tx_active, 1);
    wr(32'd9, 1'b0);
    chk("ur_fallthrough1", bus.data_to_dac, 9);
    wr(32'd10, 1'b0);
    chk("ur_level2", fifo_level, 2);
    pop();
    chk("ur_after_pop1", bus.data_to_dac, 10);
    pop();
    chk("ur_after_pop2", bus.data_to_dac, 0);
    chk("ur_none_yet", underrun_count, 0);
    pop();
    pop();
    pop();
    chk("ur_count3", underrun_count, 3);
    chk("ur_stream", tx_active, 1);
    cnt_clear = 1'b1;
    pop();
    cnt_clear = 1'b0;
    chk("ur_clear_prio", underrun_count, 0);
    wr(32'd11, 1'b0);
    chk("ur_fallthrough2", bus.data_to_dac, 11);
    do_reset();
    prefill_thresh = 6'd32;
    for (int i = 0; i < 5; i++) wr(32'h100 + i, i == 4);
    chk("short_prefill", tx_active, 0);
    tick();
    chk("short_stream", tx_active, 1);
    chk("short_level5", fifo_level, 5);
    for (int i = 0; i < 5; i++) begin
      chk("short_order", bus.data_to_dac, 32'h100 + i);
      chk("short_no_done", tx_done, 0);
      pop();
    end
    chk("short_done", tx_done, 1);
    chk("short_idle", tx_active, 0);
    chk("short_data0", bus.data_to_dac, 0);
    tick();
    chk("short_done_once", tx_done, 0);
    do_reset();
    prefill_thresh = 6'd63;
    for (int i = 0; i < 64; i++) wr(32'h200 + i, 1'b0);
    chk("full_level", fifo_level, 64);
    chk("full_fulln", bus.iq_in_fulln, 0);
    chk("full_active", tx_active, 1);
    chk("full_no_ovf", overflow, 0);
    wr(32'h999, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", fifo_level, 64);
    chk("ovf_head", bus.data_to_dac, 32'h200);
    bus.read_bb_fifo = 1'b1;
    wr(32'h998, 1'b0);
    bus.read_bb_fifo = 1'b0;
    chk("wp_full_level", fifo_level, 63);
    chk("wp_full_head", bus.data_to_dac, 32'h201);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("ovf_clear", overflow, 0);
    for (int i = 1; i < 64; i++) begin
      chk("full_drain", bus.data_to_dac, 32'h200 + i);
      pop();
    end
    chk("full_drain_level", fifo_level, 0);
    chk("full_drain_data", bus.data_to_dac, 0);
    do_reset();
    prefill_thresh = 6'd4;
    wn = 0; rn = 0; dones = 0; cyc = 0; pause_cnt = 0;
    while (rn < 300 && cyc < 3000) begin
      bus.iq_in_valid = wn < 300 && pause_cnt == 0;
      bus.iq_in = 32'(wn + 1);
      bus.iq_in_last = (wn + 1 == 150) || (wn + 1 == 300);
      bus.read_bb_fifo = tx_active && (cyc % 2 == 0);
      acc = bus.iq_in_valid && bus.iq_in_fulln;
      popd = bus.read_bb_fifo && fifo_level != 0;
      if (popd) chk("wrap_order", bus.data_to_dac, 32'(rn + 1));
      tick();
      cyc++;
      if (acc) wn++;
      if (popd) rn++;
      if (pause_cnt > 0) begin
        pause_cnt--;
        if (pause_cnt == 0) chk("wrap_reprefill", tx_active, 1);
      end
      if (tx_done) begin
        dones++;
        chk("wrap_done_inactive", tx_active, 0);
        if (dones == 1) pause_cnt = 2;
      end
    end
    bus.iq_in_valid = 1'b0;
    bus.iq_in_last = 1'b0;
    bus.read_bb_fifo = 1'b0;
    chk("wrap_all_popped", rn, 300);
    chk("wrap_two_dones", dones, 2);
    chk("wrap_idle_data", bus.data_to_dac, 0);
    do_reset();
    prefill_thresh = 6'd4;
    for (int i = 0; i < 20; i++) wr(32'h300 + i, 1'b0);
    chk("mid_level20", fifo_level, 20);
    chk("mid_active", tx_active, 1);
    acc_rstn = 1'b0;
    tick();
    acc_rstn = 1'b1;
    chk("mid_level", fifo_level, 0);
    chk("mid_fulln", bus.iq_in_fulln, 1);
    chk("mid_data", bus.data_to_dac, 0);
    chk("mid_inactive", tx_active, 0);
    chk("mid_done", tx_done, 0);
    bus.read_bb_fifo = 1'b1;
    tick();
    chk("mid_no_done", tx_done, 0);
    tick();
    tick();
    chk("mid_pop_ignored_ur", underrun_count, 0);
    chk("mid_pop_ignored_lvl", fifo_level, 0);
    wr(32'h55, 1'b0);
    tick();
    bus.read_bb_fifo = 1'b0;
    chk("mid_prefill_level", fifo_level, 1);
    chk("mid_prefill_inactive", tx_active, 0);
    chk("mid_prefill_data", bus.data_to_dac, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
